// File: rtl/negated_circular_shift_deserializer_pkg.sv
// Shared types and defaults for the twisted-ring serial link receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`ifndef NEGATED_CIRCULAR_SHIFT_DESERIALIZER_PKG_SV
`define NEGATED_CIRCULAR_SHIFT_DESERIALIZER_PKG_SV

package negated_circular_shift_deserializer_pkg;

    // Link receiver state: collecting reference bits, verifying toward lock, locked.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 5;
    localparam int DEFAULT_LOCK_LEN = 5;

endpackage

`endif

// File: rtl/negated_circular_shift_deserializer_ring_invariant_checker.sv
// Keeps the last WIDTH received bits and tests each new bit against the complement of the oldest.
// Latency: match/mismatch are combinational from serial_in and the registered history.
// Backpressure: history only advances when sample=1; sample=0 freezes it and silences both strobes.
`ifndef NEGATED_CIRCULAR_SHIFT_DESERIALIZER_RING_INVARIANT_CHECKER_SV
`define NEGATED_CIRCULAR_SHIFT_DESERIALIZER_RING_INVARIANT_CHECKER_SV

module ring_invariant_checker
    import negated_circular_shift_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clock,
    input  logic clear,
    input  logic sample,
    input  logic check_en,
    input  logic serial_in,
    output logic match,
    output logic mismatch
);

    // hist[0] is the bit received WIDTH samples ago.
    logic [WIDTH-1:0] hist;

    // Shift every sampled bit into the history, newest at the top.
    always_ff @(posedge clock) begin
        if (!clear) begin
            hist <= '0;
        end else if (sample) begin
            hist <= {serial_in, hist[WIDTH-1:1]};
        end
    end

    // A twisted ring always delivers the inverse of the bit one ring-length back.
    always_comb begin
        match    = sample & check_en & (serial_in ^ hist[0]);
        mismatch = sample & check_en & ~(serial_in ^ hist[0]);
    end

endmodule

`endif

// File: rtl/negated_circular_shift_deserializer.sv
// Rebuilds LSB-first WIDTH-bit words from a twisted-ring serial stream and reports lock/error.
// Latency: word/word_valid one cycle after the edge sampling the last bit; locked/error likewise.
// Backpressure: none upstream; serial_valid=0 holds all state and drops the one-cycle pulses.
`ifndef NEGATED_CIRCULAR_SHIFT_DESERIALIZER_SV
`define NEGATED_CIRCULAR_SHIFT_DESERIALIZER_SV

module negated_circular_shift_deserializer
    import negated_circular_shift_deserializer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int LOCK_LEN = DEFAULT_LOCK_LEN
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             locked,
    output logic             error
);

    localparam int BW = $clog2(WIDTH);
    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_LEN - 1);

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [MW-1:0]    match_cnt;
    // Holds the WIDTH-1 bits already collected for the current word, newest at the top.
    logic [WIDTH-2:0] sreg;
    logic [WIDTH-2:0] sreg_restart;
    logic [WIDTH-1:0] assembled;
    logic             word_done;
    logic             check_en;
    logic             match;
    logic             mismatch;

    // Word as it stands including the bit on the wire; complete when bit_cnt hits its last slot.
    always_comb begin
        assembled = {serial_in, sreg};
        word_done = (bit_cnt == LAST_BIT);
        check_en  = (state != HUNT);
    end

    // After a mismatch the offending bit alone is the start of the next word.
    always_comb begin
        sreg_restart           = '0;
        sreg_restart[WIDTH-2]  = serial_in;
    end

    ring_invariant_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clock     (clock),
        .clear     (clear),
        .sample    (serial_valid),
        .check_en  (check_en),
        .serial_in (serial_in),
        .match     (match),
        .mismatch  (mismatch)
    );

    // Word assembly, lock FSM and registered status outputs.
    always_ff @(posedge clock) begin
        if (!clear) begin
            word       <= '0;
            word_valid <= 1'b0;
            locked     <= 1'b0;
            error      <= 1'b0;
            sreg       <= '0;
            bit_cnt    <= '0;
            match_cnt  <= '0;
            state      <= HUNT;
        end else if (!serial_valid) begin
            word_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            error      <= 1'b0;

            // A completed word is delivered even when its last bit breaks the ring.
            if (word_done) begin
                word       <= assembled;
                word_valid <= 1'b1;
            end

            if (mismatch) begin
                // The offending bit occupies word[0] of the next word, so one bit is already in.
                error     <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                state     <= HUNT;
                sreg      <= sreg_restart;
                bit_cnt   <= BW'(1);
            end else begin
                sreg    <= assembled[WIDTH-1:1];
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                case (state)
                    // One full word in history gives the reference for checking.
                    HUNT: begin
                        if (word_done) begin
                            state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (match) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == LOCK_TGT) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end
                    end
                    // Count stays saturated at LOCK_LEN while locked.
                    LOCK: begin
                        locked <= 1'b1;
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

`endif
